// File: rtl/imem_dmem_arbiter_if.sv
// Request/response and memory-side signals of the fetch/data port arbiter.
// The slave modport is the arbiter's view; master is the core+memory side.
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic                d_req;
  logic                d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_ready;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_err;

  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;
  logic                mem_src;
  logic                busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_ready, i_rdata, i_err,
    output d_ready, d_rdata, d_err,
    output mem_req, mem_we, mem_be, mem_addr,
    output mem_wdata, mem_src, busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_ready, i_rdata, i_err,
    input  d_ready, d_rdata, d_err,
    input  mem_req, mem_we, mem_be, mem_addr,
    input  mem_wdata, mem_src, busy
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data wins by default; a starvation counter lets fetch through.
module imem_dmem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  imem_dmem_arbiter_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int WW   = $clog2(STARVE_LIMIT + 1);
  localparam int TW   =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [WW-1:0] W_MAX = WW'(STARVE_LIMIT);
  localparam logic [TW-1:0] T_LAST =
    TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_src_q, mem_src_d;
  logic              i_ready_q, i_ready_d;
  logic              i_err_q, i_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ready_q, d_ready_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              fin;
  logic              tout;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_src_d   = mem_src_q;
    i_ready_d   = 1'b0;
    i_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ready_d   = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    tcnt_d      = tcnt_q;
    wait_d      = wait_q;
    fin         = 1'b0;
    tout        = 1'b0;
    rdata       = bus.mem_rdata;

    // A fetch in flight is being served, so it is not losing.
    if (!bus.i_req)
      wait_d = '0;
    else if (wait_q != W_MAX && state_q != BUSY_I)
      wait_d = wait_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.d_req && !(bus.i_req && wait_q == W_MAX)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_src_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_be_d    = bus.d_be;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          tcnt_d      = '0;
        end else if (bus.i_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_src_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = {bus.i_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = '0;
          tcnt_d      = '0;
          wait_d      = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) begin
          fin = 1'b1;
        end else if (TO_EN && tcnt_q == T_LAST) begin
          fin   = 1'b1;
          tout  = 1'b1;
          rdata = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
        if (fin) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_ready_d = 1'b1;
            d_err_d   = tout;
            d_rdata_d = rdata;
          end else begin
            i_ready_d = 1'b1;
            i_err_d   = tout;
            i_rdata_d = rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_src_q   <= 1'b0;
      i_ready_q   <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      wait_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_src_q   <= mem_src_d;
      i_ready_q   <= i_ready_d;
      i_err_q     <= i_err_d;
      i_rdata_q   <= i_rdata_d;
      d_ready_q   <= d_ready_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      wait_q      <= wait_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_src   = mem_src_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.i_ready   = i_ready_q;
  assign bus.i_err     = i_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: grant and ready queues
// filled by the stimulus, drained by a negedge monitor.
module tb_imem_dmem_arbiter;
  logic clk;
  logic rst;

  imem_dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          src;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    bit          src;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;
  int mcnt   = 0;
  int run    = 0;
  int last_run = 0;
  bit prev_req = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic push_g(input bit s, input logic [31:0] a,
                        input bit we, input logic [3:0] be,
                        input logic [31:0] w);
    grant_t g;
    g.src = s; g.addr = a; g.we = we; g.be = be; g.wdata = w;
    gq.push_back(g);
  endtask

  task automatic push_r(input bit s, input logic [31:0] rd,
                        input bit err);
    resp_t r;
    r.src = s; r.rdata = rd; r.err = err;
    rq.push_back(r);
  endtask

  task automatic set_d(input bit we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] w);
    bus.d_we = we; bus.d_be = be; bus.d_addr = a; bus.d_wdata = w;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((bus.busy || bus.i_ready || bus.d_ready) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_wait: still busy after %0d cycles", lim);
    end
  endtask

  // Memory model: ready after lat cycles of mem_req (0 = never).
  always @(negedge clk) begin
    if (bus.mem_req && !rst) begin
      mcnt++;
      bus.mem_ready = (lat > 0) && (mcnt >= lat);
      bus.mem_rdata = rdata_of(bus.mem_addr);
    end else begin
      mcnt = 0;
      bus.mem_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    grant_t g;
    resp_t  r;
    if (bus.mem_req && !prev_req) begin
      if (gq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL grant_unexpected: src %0d addr %0h",
                 bus.mem_src, bus.mem_addr);
      end else begin
        g = gq.pop_front();
        chk("grant_src", 64'(bus.mem_src), 64'(g.src));
        chk("grant_addr", 64'(bus.mem_addr), 64'(g.addr));
        chk("grant_we", 64'(bus.mem_we), 64'(g.we));
        chk("grant_be", 64'(bus.mem_be), 64'(g.be));
        if (g.src)
          chk("grant_wdata", 64'(bus.mem_wdata), 64'(g.wdata));
      end
    end
    if (bus.mem_req) begin
      run++;
    end else if (prev_req) begin
      last_run = run;
      run = 0;
    end
    prev_req = bus.mem_req;
    if (bus.i_ready || bus.d_ready) begin
      chk("ready_both", 64'(bus.i_ready & bus.d_ready), 64'd0);
      if (rq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ready_unexpected: i_ready %0d d_ready %0d",
                 bus.i_ready, bus.d_ready);
      end else begin
        r = rq.pop_front();
        chk("ready_src", 64'(bus.d_ready), 64'(r.src));
        if (r.src) begin
          chk("d_rdata", 64'(bus.d_rdata), 64'(r.rdata));
          chk("d_err", 64'(bus.d_err), 64'(r.err));
        end else begin
          chk("i_rdata", 64'(bus.i_rdata), 64'(r.rdata));
          chk("i_err", 64'(bus.i_err), 64'(r.err));
        end
      end
    end
  end

  initial begin
    rst = 1;
    bus.i_req = 1; bus.i_addr = 32'h80;
    bus.d_req = 1;
    set_d(0, 4'hF, 32'h40, 32'h1111_2222);
    bus.mem_ready = 0; bus.mem_rdata = '0;

    // Reset with both requests pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_ctl", 64'({bus.mem_req, bus.mem_we, bus.mem_be,
                          bus.mem_src, bus.busy}), 64'd0);
      chk("rst_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_rdy", 64'({bus.i_ready, bus.i_err,
                          bus.d_ready, bus.d_err}), 64'd0);
      chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
    end
    push_g(1, 32'h40, 0, 4'hF, 32'h1111_2222);
    push_r(1, 32'hCAFE_0040, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_first_req", 64'({bus.mem_req, bus.mem_src}), 64'd3);
    bus.i_req = 0; bus.d_req = 0;
    wait_idle(10);

    // Single fetch, memory answers two cycles later
    lat = 2;
    bus.i_addr = 32'h103;
    bus.i_req = 1;
    push_g(0, 32'h100, 0, 4'hF, 32'h0);
    push_r(0, 32'h0000_0013, 0);
    @(negedge clk);
    bus.i_req = 0;
    wait_idle(10);

    // Starvation: D, D, then I on the 5th edge
    lat = 1;
    set_d(0, 4'hF, 32'h300, 32'h0);
    bus.i_addr = 32'h400;
    push_g(1, 32'h300, 0, 4'hF, 32'h0);
    push_g(1, 32'h300, 0, 4'hF, 32'h0);
    push_g(0, 32'h400, 0, 4'hF, 32'h0);
    push_r(1, 32'hCAFE_0300, 0);
    push_r(1, 32'hCAFE_0300, 0);
    push_r(0, 32'hCAFE_0400, 0);
    bus.i_req = 1; bus.d_req = 1;
    repeat (5) @(negedge clk);
    chk("starve_5th_edge", 64'({bus.mem_req, bus.mem_src}), 64'd2);
    bus.i_req = 0; bus.d_req = 0;
    wait_idle(10);

    // Simultaneous: store first, fetch next
    set_d(1, 4'h3, 32'h200, 32'hDEAD_BEEF);
    bus.i_addr = 32'h104;
    push_g(1, 32'h200, 1, 4'h3, 32'hDEAD_BEEF);
    push_g(0, 32'h104, 0, 4'hF, 32'h0);
    push_r(1, 32'hCAFE_0200, 0);
    push_r(0, 32'hCAFE_0104, 0);
    bus.i_req = 1; bus.d_req = 1;
    repeat (2) @(negedge clk);
    chk("simul_dready_lat", 64'(bus.d_ready), 64'd1);
    bus.d_req = 0;
    @(negedge clk);
    bus.i_req = 0;
    wait_idle(10);

    // Timeout on a load that never completes
    lat = 0;
    set_d(0, 4'hF, 32'h500, 32'h0);
    push_g(1, 32'h500, 0, 4'hF, 32'h0);
    push_r(1, 32'h0, 1);
    bus.d_req = 1;
    @(negedge clk);
    bus.d_req = 0;
    wait_idle(100);
    chk("timeout_req_cycles", 64'(last_run), 64'd64);

    lat = 1;
    bus.i_addr = 32'h600;
    push_g(0, 32'h600, 0, 4'hF, 32'h0);
    push_r(0, 32'hCAFE_0600, 0);
    bus.i_req = 1;
    @(negedge clk);
    bus.i_req = 0;
    wait_idle(10);

    // Completion on the 64th edge beats the timeout
    lat = 64;
    set_d(0, 4'hF, 32'h504, 32'h0);
    push_g(1, 32'h504, 0, 4'hF, 32'h0);
    push_r(1, 32'hCAFE_0504, 0);
    bus.d_req = 1;
    @(negedge clk);
    bus.d_req = 0;
    wait_idle(100);
    chk("late_ready_cycles", 64'(last_run), 64'd64);

    // Asynchronous reset while a load is outstanding
    lat = 0;
    set_d(0, 4'hF, 32'h700, 32'h0);
    push_g(1, 32'h700, 0, 4'hF, 32'h0);
    bus.d_req = 1;
    @(negedge clk);
    bus.d_req = 0;
    chk("rstmid_before", 64'({bus.mem_req, bus.busy}), 64'd3);
    #2 rst = 1;
    #1 chk("rstmid_async", 64'({bus.mem_req, bus.busy}), 64'd0);
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);

    chk("resp_queue_empty", 64'(rq.size()), 64'd0);
    chk("grant_queue_empty", 64'(gq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one 32-bit memory port between two requesters: the instruction fetch path (read-only) and the load/store path (read/write).
- Sits between the core pipeline and the unified memory.
- Serialises accesses with a small FSM. Data requests have priority by default, bounded by an anti-starvation counter for fetch.
- A timeout aborts any access the memory never completes.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_LIMIT, 4, number of lost arbitration edges after which a pending fetch beats a pending data request (must be ≥ 1)
- TIMEOUT_CYCLES, 64, number of cycles mem_req may stay high without mem_ready before abort; 0 disables the timeout

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level; held high means another access is wanted
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  one-cycle pulse: fetch access complete
- i_rdata  out  DATA_W  fetch read data, valid when i_ready=1
- i_err  out  1  pulses with i_ready on a timeout abort
- d_req  in  1  data request, level
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data, valid when d_ready=1
- d_err  out  1  pulses with d_ready on a timeout abort
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes the access at this edge
- mem_src  out  1  owner of the current access: 0 = fetch, 1 = data
- busy  out  1  1 while in BUSY_I or BUSY_D

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - FSM goes to IDLE; counters clear.
  - All outputs are 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, all ready/err/rdata outputs, mem_src, busy.
  - Reset during BUSY drops mem_req immediately; no ready pulse is ever issued for the aborted access.
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE, at each edge:
  - d_req only → BUSY_D.
  - i_req only → BUSY_I.
  - Both high → BUSY_D, unless i_wait ≥ STARVE_LIMIT, in which case → BUSY_I.
  - Neither high → stay in IDLE.
- Grant edge actions:
  - Latch the request into the mem_* registers; set mem_req=1 and busy=1.
  - Fetch grant: mem_we=0, mem_be=all ones, mem_addr = i_addr with bits [1:0] forced to 0.
  - Data grant: mem_we, mem_be, mem_addr, mem_wdata taken verbatim from the d_* inputs.
  - mem_* outputs stay stable until the access ends. Requester input changes after the grant edge are ignored.
- BUSY_x, edge with mem_ready=1:
  - Go to IDLE; mem_req=0 and busy=0.
  - Register x_rdata = mem_rdata and pulse x_ready=1 for exactly one cycle (the IDLE cycle).
  - For stores, x_rdata = mem_rdata as returned; it is don't-care to the requester.
- BUSY_x, timeout (TIMEOUT_CYCLES > 0):
  - Cycle counter clears on grant and increments at each BUSY edge with mem_ready=0.
  - At the edge where the count would reach TIMEOUT_CYCLES: go to IDLE, mem_req=0, pulse x_ready and x_err together, x_rdata=0.
  - mem_ready=1 on that same edge is a normal completion; completion wins over timeout.
- Latency:
  - Request sampled at edge E0 → mem_req high after E0.
  - mem_ready sampled at E1 or later → x_ready high for the following cycle.
  - Next arbitration happens at the edge ending the ready cycle.
  - Minimum 3 cycles request-to-ready; peak throughput is one access per 2 cycles.
- Request protocol:
  - A requester still holding req on the edge that ends its ready cycle issues a new request with its current address.
  - Fetch may hold i_req continuously.
- Starvation counter i_wait:
  - Increments (saturating at STARVE_LIMIT) at each edge where i_req=1 and fetch is not granted.
  - Clears on a fetch grant or when i_req=0 is sampled.
- x_rdata holds its value between ready pulses. x_ready and x_err are 0 except on the pulse cycle.

Test Plan:
- Reset: assert rst with i_req=1 and d_req=1 → all outputs 0 throughout. Deassert rst → first mem_req appears after the next edge, with mem_src=1.
- Single fetch: i_req=1, i_addr=0x103; memory returns mem_ready=1 two cycles after mem_req with mem_rdata=0x00000013 → mem_addr=0x100, mem_we=0, mem_be=0xF; i_ready=1 for one cycle with i_rdata=0x00000013; d_ready stays 0.
- Simultaneous requests: i_req and d_req both high; store to 0x200, wdata 0xDEADBEEF, be 0x3; mem_ready tied 1 → first access mem_we=1, mem_be=0x3, mem_src=1, d_ready pulse; second access mem_src=0 at fetch address.
- Starvation: d_req and i_req held high, mem_ready tied 1, STARVE_LIMIT=4 → grants are D, D, I in order; the fetch mem_req appears after the 5th edge; i_wait clears afterward.
- Timeout: load granted, mem_ready held 0 → exactly 64 cycles of mem_req=1, then d_ready=1, d_err=1, d_rdata=0 for one cycle. A new i_req is then granted normally. Repeat with mem_ready=1 on the 64th edge → normal completion, d_err=0.
- Reset mid-access: assert rst asynchronously while in BUSY_D → mem_req and busy fall without a clock edge; no d_ready pulse follows after reset is released.
